ifns_11di_serial_encoder: RTL and testbench

Sequential IFNS encoder for the 11-bit data-in variant. It converts an 11-bit binary value into the 16-bit IFNS codeword that the 11-bit IFNS decoder core consumes. It sits directly upstream of that decoder on the codec path. Each word is converted MSB-first by greedy weight subtraction, one codeword bit per clock, with valid/ready handshakes on both sides.

---
 rtl/ifns_11di_serial_encoder.sv | 124 ++++++++++++
 tb/tb_ifns_11di_serial_encoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ifns_11di_serial_encoder.sv
// Serial IFNS encoder: 11-bit binary in, 16-bit IFNS codeword out, one bit per clock MSB-first.
// Optional self-check of the finished codeword is enabled by defining IFNS_ENC_SELFCHECK_EN.
module ifns_11di_serial_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] din,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] dout,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] rem_q, rem_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cw_q, cw_d;
  logic [10:0] w_cur;

  function automatic logic [10:0] weight(input logic [3:0] i);
    case (i)
      4'd15:   weight = 11'd1597;
      4'd14:   weight = 11'd610;
      4'd13:   weight = 11'd377;
      4'd12:   weight = 11'd233;
      4'd11:   weight = 11'd144;
      4'd10:   weight = 11'd89;
      4'd9:    weight = 11'd55;
      4'd8:    weight = 11'd34;
      4'd7:    weight = 11'd21;
      4'd6:    weight = 11'd13;
      4'd5:    weight = 11'd8;
      4'd4:    weight = 11'd5;
      4'd3:    weight = 11'd3;
      4'd2:    weight = 11'd2;
      default: weight = 11'd1;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    cw_d    = cw_q;
    w_cur   = weight(idx_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          rem_d   = din;
          idx_d   = 4'd15;
          cw_d    = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Greedy subtraction never underflows: only taken when rem >= weight.
        if (rem_q >= w_cur) begin
          cw_d[idx_q] = 1'b1;
          rem_d       = rem_q - w_cur;
        end
        if (idx_q == 4'd0) state_d = DONE;
        else               idx_d   = idx_q - 4'd1;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      cw_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      cw_q    <= cw_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign dout      = out_valid ? cw_q : '0;

`ifdef IFNS_ENC_SELFCHECK_EN
  logic [10:0] din_q;
  logic [11:0] sum;
  logic        err_q;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (cw_q[i]) sum = sum + {1'b0, weight(4'(i))};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) din_q <= din;
      // Sticky: once a codeword disagrees with its input, stay flagged until reset.
      if (state_q == DONE && (sum != {1'b0, din_q} || rem_q != '0)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ifns_11di_serial_encoder.sv
// Directed and sweep bench for ifns_11di_serial_encoder; valid with or without IFNS_ENC_SELFCHECK_EN.
module tb_ifns_11di_serial_encoder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] din;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic        err;

  int total;
  int bad;

  ifns_11di_serial_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_decode(input logic [15:0] cw);
    int w[16];
    int s;
    w = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 1597};
    s = 0;
    for (int i = 0; i < 16; i++) if (cw[i]) s += w[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word and hold it until the encoder takes it; ok=0 if never taken.
  task automatic accept(input logic [10:0] v, output bit ok);
    bit was_rdy;
    in_valid = 1'b1;
    din      = v;
    ok       = 1'b0;
    for (int i = 0; i < 60; i++) begin
      was_rdy = in_ready;
      tick();
      if (was_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    in_valid = 1'b0;
    din      = '0;
  endtask

  task automatic wait_valid(output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 100) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (dout !== 16'h0000) begin bad++; $display("FAIL reset_dout got=%h want=0000", dout); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
  endtask

  task automatic test_vectors();
    logic [10:0] vin[6];
    logic [15:0] vexp[6];
    bit ok;
    int cyc;
    vin  = '{11'd0, 11'd1, 11'd100, 11'd1597, 11'd1596, 11'd2047};
    vexp = '{16'h0000, 16'h0002, 16'h0428, 16'h8000, 16'h7FFF, 16'hA250};
    for (int k = 0; k < 6; k++) begin
      accept(vin[k], ok);
      total++; if (!ok) begin bad++; $display("FAIL vec_accept din=%0d got=timeout want=accepted", vin[k]); end
      wait_valid(cyc, ok);
      total++; if (!ok) begin bad++; $display("FAIL vec_valid din=%0d got=timeout want=out_valid", vin[k]); end
      total++; if (cyc != 16) begin bad++; $display("FAIL vec_latency din=%0d got=%0d want=16", vin[k], cyc); end
      total++; if (dout !== vexp[k]) begin bad++; $display("FAIL vec_dout din=%0d got=%h want=%h", vin[k], dout, vexp[k]); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL vec_err din=%0d got=%b want=0", vin[k], err); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        bad++; $display("FAIL vec_release din=%0d got=ov%b ir%b want=ov0 ir1", vin[k], out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int cyc;
    accept(11'd100, ok);
    wait_valid(cyc, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_valid got=timeout want=out_valid"); end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    din       = 11'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++; if (dout !== 16'h0428 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h ov%b ir%b want=0428 ov1 ir0", i, dout, out_valid, in_ready);
      end
    end
    in_valid  = 1'b0;
    din       = '0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release got=ov%b ir%b want=ov0 ir1", out_valid, in_ready);
    end
    repeat (3) tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_no_accept got=ir%b ov%b want=ir1 ov0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    accept(11'd2047, ok);
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 16'h0000) begin
      bad++; $display("FAIL midrst_state got=ir%b ov%b dout=%h want=ir1 ov0 dout=0000", in_ready, out_valid, dout);
    end
    repeat (20) tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_output got=%b want=0", out_valid); end
    accept(11'd100, ok);
    wait_valid(cyc, ok);
    total++; if (!ok || dout !== 16'h0428) begin bad++; $display("FAIL midrst_next got=%h want=0428", dout); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_sweep();
    bit ok;
    bit done;
    logic [15:0] cap;
    for (int v = 0; v < 2048; v++) begin
      accept(11'(v), ok);
      if (!ok) begin
        total++; bad++; $display("FAIL sweep_accept din=%0d got=timeout want=accepted", v);
        continue;
      end
      done = 1'b0;
      cap  = '0;
      for (int c = 0; c < 300 && !done; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid) begin
          if (cap == 16'h0000) cap = dout;
          else if (dout !== cap) begin
            total++; bad++; $display("FAIL sweep_stable din=%0d got=%h want=%h", v, dout, cap);
          end
          if (out_ready) begin
            cap = dout;
            total++; if (ref_decode(cap) != v) begin bad++; $display("FAIL sweep_decode din=%0d got=%0d cw=%h", v, ref_decode(cap), cap); end
            total++; if (err !== 1'b0) begin bad++; $display("FAIL sweep_err din=%0d got=%b want=0", v, err); end
            done = 1'b1;
          end
        end
        tick();
      end
      out_ready = 1'b0;
      if (!done) begin
        total++; bad++; $display("FAIL sweep_done din=%0d got=timeout want=handshake", v);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
